// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8-bit UART receiver (8N1 / 8E1) feeding a first-word-fall-through byte FIFO.
module uart_rx_fifo #(
   parameter int unsigned DIV_W      = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rx_i,
   input  logic [DIV_W-1:0]            cfg_div_i,
   input  logic                        cfg_parity_en_i,
   output logic [7:0]                  rx_data_o,
   output logic                        rx_valid_o,
   input  logic                        rx_ready_i,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
   output logic                        busy_o,
   output logic                        err_frame_o,
   output logic                        err_parity_o,
   output logic                        err_overflow_o
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   // receiver state
   state_t            state_q, state_d;
   logic [1:0]        sync_q, sync_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              par_en_q, par_en_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_err_q, par_err_d;
   logic              push_q, push_d;
   logic [7:0]        push_data_q, push_data_d;
   logic              err_frame_q, err_frame_d;
   logic              err_parity_q, err_parity_d;
   logic              busy_q, busy_d;

   // FIFO state
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [7:0]        mem_d [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;

   logic              rxs;
   logic              bit_done;
   logic [DIV_W-1:0]  half_m1;
   logic              pop, full, wr_en;

   assign rxs      = sync_q[1];
   assign bit_done = (cnt_q == div_q - DIV_W'(1));
   assign half_m1  = (div_q >> 1) - DIV_W'(1);

   // Receiver next-state: start validation at mid start bit, then one sample per bit time
   always_comb begin
      state_d      = state_q;
      sync_d       = {sync_q[0], rx_i};
      cnt_d        = cnt_q;
      div_d        = div_q;
      par_en_d     = par_en_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_err_d    = par_err_q;
      push_d       = 1'b0;
      push_data_d  = push_data_q;
      err_frame_d  = 1'b0;
      err_parity_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               state_d   = S_START;
               cnt_d     = '0;
               bit_cnt_d = '0;
               par_err_d = 1'b0;
               div_d     = (cfg_div_i < DIV_MIN) ? DIV_MIN : cfg_div_i;
               par_en_d  = cfg_parity_en_i;
            end
         end
         S_START: begin
            if (cnt_q == half_m1) begin
               cnt_d   = '0;
               state_d = rxs ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         S_DATA: begin
            if (bit_done) begin
               cnt_d     = '0;
               shift_d   = {rxs, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         S_PARITY: begin
            if (bit_done) begin
               cnt_d     = '0;
               par_err_d = ((^shift_q) != rxs);
               state_d   = S_STOP;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         S_STOP: begin
            if (bit_done) begin
               cnt_d = '0;
               if (rxs) begin
                  state_d = S_IDLE;
                  if (par_err_q) begin
                     err_parity_d = 1'b1;
                  end else begin
                     push_d      = 1'b1;
                     push_data_d = shift_q;
                  end
               end else begin
                  err_frame_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         S_BREAK: begin
            if (rxs) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // FIFO next-state: circular buffer, head byte registered with bypass for push into empty
   always_comb begin
      pop   = valid_q & rx_ready_i;
      full  = (count_q == CW'(FIFO_DEPTH));
      wr_en = push_q & (~full | pop);
      ovf_d = push_q & full & ~pop;
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = push_data_q;
      end
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(wr_en) - CW'(pop);
      valid_d  = (count_d != '0);
      data_d   = data_q;
      if (count_d != '0) begin
         data_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? push_data_q : mem_q[rd_ptr_d];
      end
   end

   // Receiver registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sync_q       <= 2'b11;
         cnt_q        <= '0;
         div_q        <= DIV_MIN;
         par_en_q     <= 1'b0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_err_q    <= 1'b0;
         push_q       <= 1'b0;
         push_data_q  <= '0;
         err_frame_q  <= 1'b0;
         err_parity_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         par_en_q     <= par_en_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_err_q    <= par_err_d;
         push_q       <= push_d;
         push_data_q  <= push_data_d;
         err_frame_q  <= err_frame_d;
         err_parity_q <= err_parity_d;
         busy_q       <= busy_d;
      end
   end

   // FIFO registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   assign rx_data_o      = data_q;
   assign rx_valid_o     = valid_q;
   assign fifo_count_o   = count_q;
   assign busy_o         = busy_q;
   assign err_frame_o    = err_frame_q;
   assign err_parity_o   = err_parity_q;
   assign err_overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives serial frames into uart_rx_fifo and checks against a queue model.
module tb_uart_rx_fifo;
   localparam int unsigned DIV_W = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             rx_i;
   logic [DIV_W-1:0] cfg_div_i;
   logic             cfg_parity_en_i;
   logic [7:0]       rx_data_o;
   logic             rx_valid_o;
   logic             rx_ready_i;
   logic [CW-1:0]    fifo_count_o;
   logic             busy_o;
   logic             err_frame_o;
   logic             err_parity_o;
   logic             err_overflow_o;

   int checks   = 0;
   int failures = 0;
   int n_frame  = 0, n_par = 0, n_ovf = 0;
   int e_frame  = 0, e_par = 0, e_ovf = 0;
   logic [7:0] model_q [$];
   logic [7:0] last_pop;
   bit         busy_seen;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_i           (rx_i),
      .cfg_div_i      (cfg_div_i),
      .cfg_parity_en_i(cfg_parity_en_i),
      .rx_data_o      (rx_data_o),
      .rx_valid_o     (rx_valid_o),
      .rx_ready_i     (rx_ready_i),
      .fifo_count_o   (fifo_count_o),
      .busy_o         (busy_o),
      .err_frame_o    (err_frame_o),
      .err_parity_o   (err_parity_o),
      .err_overflow_o (err_overflow_o)
   );

   // Count every cycle an error flag is high; a stretched pulse shows up as an extra count
   always @(negedge clk) begin
      if (err_frame_o)    n_frame++;
      if (err_parity_o)   n_par++;
      if (err_overflow_o) n_ovf++;
      if (busy_o)         busy_seen = 1'b1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int n);
      rx_i = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input int bt, input bit par_en,
                             input bit pbit, input bit stop_bit, input int hold_bits);
      drive_bit(1'b0, bt);
      for (int i = 0; i < 8; i++) drive_bit(b[i], bt);
      if (par_en) drive_bit(pbit, bt);
      drive_bit(stop_bit, bt);
      if (!stop_bit && hold_bits > 0) drive_bit(1'b0, bt * hold_bits);
      rx_i = 1'b1;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_frm"},  32'(n_frame), 32'(e_frame));
      chk({tag, "_par"},  32'(n_par),   32'(e_par));
      chk({tag, "_ovf"},  32'(n_ovf),   32'(e_ovf));
      chk({tag, "_cnt"},  32'(fifo_count_o), 32'(model_q.size()));
      chk({tag, "_vld"},  32'(rx_valid_o),   32'(model_q.size() != 0));
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      if (model_q.size() != 0) chk({tag, "_head"}, 32'(rx_data_o), 32'(model_q[0]));
   endtask

   // mode: 0 good, 1 bad parity (only when parity enabled), 2 stop bit low
   task automatic run_frame(input string tag, input logic [7:0] b, input logic [DIV_W-1:0] div,
                            input bit par_en, input int mode, input int hold_bits);
      int bt;
      bit bad_par, bad_stop, pbit;
      cfg_div_i       = div;
      cfg_parity_en_i = par_en;
      bt       = (div < 4) ? 4 : int'(div);
      bad_stop = (mode == 2);
      bad_par  = par_en && (mode == 1);
      pbit     = (^b) ^ bad_par;
      send_frame(b, bt, par_en, pbit, !bad_stop, hold_bits);
      if (bad_stop)                    e_frame++;
      else if (bad_par)                e_par++;
      else if (model_q.size() == DEPTH) e_ovf++;
      else                             model_q.push_back(b);
      idle(3 * bt + 8);
      check_state(tag);
   endtask

   task automatic pop_one(input string tag);
      logic [7:0] exp;
      exp = model_q.pop_front();
      chk({tag, "_pvld"}, 32'(rx_valid_o), 32'd1);
      chk({tag, "_pdat"}, 32'(rx_data_o), 32'(exp));
      rx_ready_i = 1'b1;
      @(negedge clk);
      rx_ready_i = 1'b0;
      last_pop = exp;
      chk({tag, "_pcnt"}, 32'(fifo_count_o), 32'(model_q.size()));
      if (model_q.size() == 0) chk({tag, "_hold"}, 32'(rx_data_o), 32'(last_pop));
   endtask

   task automatic pop_empty(input string tag);
      rx_ready_i = 1'b1;
      @(negedge clk);
      rx_ready_i = 1'b0;
      chk({tag, "_ecnt"}, 32'(fifo_count_o), 32'd0);
      chk({tag, "_evld"}, 32'(rx_valid_o), 32'd0);
      chk({tag, "_edat"}, 32'(rx_data_o), 32'(last_pop));
   endtask

   initial begin
      int t;
      int np;
      int mode;
      logic [7:0] b;
      logic [7:0] exp_head;

      rst = 1'b1; rx_i = 1'b1; rx_ready_i = 1'b0;
      cfg_div_i = DIV_W'(32); cfg_parity_en_i = 1'b0;
      last_pop = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_data", 32'(rx_data_o), 32'h0);
      chk("rst_vld",  32'(rx_valid_o), 32'd0);
      chk("rst_cnt",  32'(fifo_count_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_err",  32'({err_frame_o, err_parity_o, err_overflow_o}), 32'd0);

      // basic receive, parity good/bad, framing error with long break
      run_frame("b65", 8'h65, DIV_W'(32), 1'b0, 0, 0);
      run_frame("pA5ok", 8'hA5, DIV_W'(32), 1'b1, 0, 0);
      run_frame("pA5bad", 8'hA5, DIV_W'(32), 1'b1, 1, 0);
      run_frame("brk3C", 8'h3C, DIV_W'(32), 1'b0, 2, 20);
      run_frame("b11", 8'h11, DIV_W'(32), 1'b0, 0, 0);
      pop_one("d0"); pop_one("d1"); pop_one("d2");
      pop_empty("e0");

      // overflow on 5th byte, then in-order drain
      for (int i = 1; i <= 5; i++) run_frame("ovf", 8'(i), DIV_W'(16), 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) pop_one("drain");
      pop_empty("e1");

      // glitch shorter than half a bit: busy pulses, nothing else happens
      cfg_div_i = DIV_W'(32);
      busy_seen = 1'b0;
      drive_bit(1'b0, 8);
      idle(80);
      chk("gl_busy_seen", 32'(busy_seen), 32'd1);
      check_state("gl");

      // full FIFO, pop exactly in the push cycle: both succeed, no overflow
      for (int i = 0; i < 4; i++) run_frame("fill", 8'($urandom), DIV_W'(8), 1'b0, 0, 0);
      b = 8'h9E;
      cfg_div_i = DIV_W'(8); cfg_parity_en_i = 1'b0;
      fork
         send_frame(b, 8, 1'b0, 1'b0, 1'b1, 0);
         begin
            t = 0;
            while (!busy_o && t < 400) begin @(negedge clk); t++; end
            while (busy_o && t < 400) begin @(negedge clk); t++; end
            chk("pp_wait", 32'(t < 400), 32'd1);
            exp_head = model_q.pop_front();
            chk("pp_head", 32'(rx_data_o), 32'(exp_head));
            rx_ready_i = 1'b1;
            @(negedge clk);
            rx_ready_i = 1'b0;
         end
      join
      model_q.push_back(b);
      idle(40);
      check_state("pp");
      while (model_q.size() != 0) pop_one("ppd");

      // reset during DATA of 0x77 with two bytes queued
      run_frame("q0", 8'hC3, DIV_W'(16), 1'b0, 0, 0);
      run_frame("q1", 8'h5A, DIV_W'(16), 1'b0, 0, 0);
      cfg_div_i = DIV_W'(16);
      drive_bit(1'b0, 16);
      drive_bit(1'b1, 16); drive_bit(1'b1, 16); drive_bit(1'b1, 8);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rx_i = 1'b1;
      rst = 1'b0;
      model_q.delete();
      last_pop = 8'h00;
      idle(40);
      check_state("rstmid");
      chk("rstmid_data", 32'(rx_data_o), 32'h0);
      run_frame("b42", 8'h42, DIV_W'(16), 1'b0, 0, 0);
      pop_one("p42");

      // randomized frames, configs and consumer pops
      for (int k = 0; k < 30; k++) begin
         b    = 8'($urandom);
         mode = $urandom_range(0, 4);
         if (mode > 2) mode = 0;
         run_frame("rnd", b, DIV_W'($urandom_range(0, 24)), 1'($urandom_range(0, 1)), mode,
                   $urandom_range(0, 3));
         np = $urandom_range(0, 2);
         for (int j = 0; j < np; j++) begin
            if (model_q.size() != 0) pop_one("rp");
            else pop_empty("re");
         end
      end
      while (model_q.size() != 0) pop_one("fin");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
